// File: rtl/mem_array_clr.sv
// mem_array_clr: single-clock DEPTH x WIDTH memory array with a hardware clear sequencer.
//
// After reset and on request, a sweep writes INIT_VAL to every location, one per cycle.
// While the sweep runs, busy is high and user reads and writes are ignored. There is one
// synchronous write port and one registered read port with a latency of one cycle.
// Accesses to addresses >= DEPTH are dropped (writes) or return zero (reads). Either kind
// raises a one-cycle addr_err pulse in the response cycle.
//
// Optional feature, selected with the macro MEM_WR_BYPASS_EN:
//   defined   - a read and a write to the same valid address in the same cycle return
//               wr_data (write-first forwarding).
//   undefined - the same collision returns the old contents (read-first).
//
// Ports:
//   clk       clock; all logic updates on the rising edge
//   rst_n     synchronous active-low reset; restarts the clear sweep
//   clr_req   one-cycle request to clear the whole array again (ignored while busy)
//   busy      high while the clear sweep runs
//   wr_en     write strobe
//   wr_addr   write address
//   wr_data   write data
//   rd_en     read strobe
//   rd_addr   read address
//   rd_data   registered read data
//   rd_valid  rd_data carries a read response this cycle
//   addr_err  one-cycle pulse on an out-of-range access
module mem_array_clr #(
  parameter int unsigned      WIDTH    = 8,
  parameter int unsigned      DEPTH    = 10,
  parameter int unsigned      ADDR_W   = 4,
  parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_req,
  output logic              busy,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data,
  output logic              rd_valid,
  output logic              addr_err
);

  // One extra bit so that DEPTH == 2**ADDR_W can still be represented.
  localparam logic [ADDR_W:0]   DepthLim = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LastPtr  = ADDR_W'(DEPTH - 1);

  typedef enum logic [0:0] {
    StClear,
    StReady
  } state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  clr_ptr_q, clr_ptr_d;
  logic [WIDTH-1:0]   rd_data_q, rd_data_d;
  logic               rd_valid_q, rd_valid_d;
  logic               addr_err_q, addr_err_d;

  // The contents are defined only by the sweep, so the array itself is not reset.
  logic [WIDTH-1:0]   mem_q [DEPTH];

  logic               mem_we;
  logic [ADDR_W-1:0]  mem_waddr;
  logic [WIDTH-1:0]   mem_wdata;

  logic               wr_ok;
  logic               rd_ok;

  assign wr_ok = ({1'b0, wr_addr} < DepthLim);
  assign rd_ok = ({1'b0, rd_addr} < DepthLim);

  always_comb begin
    state_d    = state_q;
    clr_ptr_d  = clr_ptr_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    addr_err_d = 1'b0;
    mem_we     = 1'b0;
    mem_waddr  = clr_ptr_q;
    mem_wdata  = INIT_VAL;

    unique case (state_q)
      StClear: begin
        // User strobes and clr_req are ignored for the whole sweep.
        mem_we    = 1'b1;
        mem_waddr = clr_ptr_q;
        mem_wdata = INIT_VAL;
        if (clr_ptr_q == LastPtr) begin
          state_d   = StReady;
          clr_ptr_d = '0;
        end else begin
          clr_ptr_d = clr_ptr_q + 1'b1;
        end
      end

      StReady: begin
        if (wr_en && wr_ok) begin
          mem_we    = 1'b1;
          mem_waddr = wr_addr;
          mem_wdata = wr_data;
        end

        if (rd_en) begin
          rd_valid_d = 1'b1;
          rd_data_d  = rd_ok ? mem_q[rd_addr] : '0;
`ifdef MEM_WR_BYPASS_EN
          if (wr_en && rd_ok && (wr_addr == rd_addr)) begin
            rd_data_d = wr_data;
          end
`endif
        end

        // A bad read and a bad write in the same cycle share one pulse.
        addr_err_d = (wr_en && !wr_ok) || (rd_en && !rd_ok);

        // The access in the request cycle has been serviced above.
        if (clr_req) begin
          state_d   = StClear;
          clr_ptr_d = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StClear;
      clr_ptr_q  <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_ptr_q  <= clr_ptr_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      addr_err_q <= addr_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign busy     = (state_q == StClear);
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign addr_err = addr_err_q;

endmodule

// File: tb/tb_mem_array_clr.sv
module tb_mem_array_clr;

  localparam int unsigned WIDTH  = 8;
  localparam int unsigned DEPTH  = 10;
  localparam int unsigned ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              clr_req;
  logic              busy;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_data;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [WIDTH-1:0]  rd_data;
  logic              rd_valid;
  logic              addr_err;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_array_clr #(
    .WIDTH   (WIDTH),
    .DEPTH   (DEPTH),
    .ADDR_W  (ADDR_W),
    .INIT_VAL(8'h00)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_req (clr_req),
    .busy    (busy),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .rd_valid(rd_valid),
    .addr_err(addr_err)
  );

  // Reference model: a clear is treated as wiping the whole array at once, because
  // nothing can be observed or written until the busy window ends.
  logic [WIDTH-1:0] m_mem [DEPTH];
  int               m_busy_left = 0;
  logic             m_valid = 1'b0;
  logic             m_err = 1'b0;
  logic [WIDTH-1:0] m_data = '0;

  task automatic model_wipe();
    for (int i = 0; i < int'(DEPTH); i++) m_mem[i] = 8'h00;
  endtask

  task automatic model_step();
    bit wa_ok, ra_ok;
    wa_ok = 32'(wr_addr) < DEPTH;
    ra_ok = 32'(rd_addr) < DEPTH;
    if (!rst_n) begin
      m_busy_left = DEPTH;
      m_valid = 1'b0;
      m_err = 1'b0;
      m_data = '0;
      model_wipe();
    end else if (m_busy_left > 0) begin
      m_busy_left--;
      m_valid = 1'b0;
      m_err = 1'b0;
    end else begin
      m_err = (wr_en && !wa_ok) || (rd_en && !ra_ok);
      m_valid = rd_en;
      if (rd_en) begin
        m_data = ra_ok ? m_mem[rd_addr] : 8'h00;
`ifdef MEM_WR_BYPASS_EN
        if (wr_en && ra_ok && wr_addr == rd_addr) m_data = wr_data;
`endif
      end
      if (wr_en && wa_ok) m_mem[wr_addr] = wr_data;
      if (clr_req) begin
        m_busy_left = DEPTH;
        model_wipe();
      end
    end
  endtask

  task automatic drive(input logic r, input logic c, input logic we, input logic [3:0] wa,
                       input logic [7:0] wd, input logic re, input logic [3:0] ra);
    rst_n = r; clr_req = c; wr_en = we; wr_addr = wa; wr_data = wd; rd_en = re; rd_addr = ra;
  endtask

  task automatic idle();
    drive(1'b1, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0);
  endtask

  // Advance one clock, keeping the model in step, and sample just after the edge.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string name);
    logic e_busy;
    e_busy = (m_busy_left > 0);
    n_vec++;
    if (busy !== e_busy || rd_valid !== m_valid || addr_err !== m_err || rd_data !== m_data) begin
      n_bad++;
      $display("FAIL %s @%0t: got busy=%b valid=%b err=%b data=%h, want busy=%b valid=%b err=%b data=%h",
               name, $time, busy, rd_valid, addr_err, rd_data, e_busy, m_valid, m_err, m_data);
    end
  endtask

  task automatic check_val(input string name, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0d, want %0d", name, $time, got, want);
    end
  endtask

  typedef struct {
    logic       rst_n;
    logic       clr;
    logic       we;
    logic [3:0] wa;
    logic [7:0] wd;
    logic       re;
    logic [3:0] ra;
    logic       e_busy;
    logic       e_valid;
    logic       e_err;
    logic [7:0] e_data;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic c, input logic we, input logic [3:0] wa,
                     input logic [7:0] wd, input logic re, input logic [3:0] ra,
                     input logic eb, input logic ev, input logic ee, input logic [7:0] ed);
    vec_t v;
    v.rst_n = r; v.clr = c; v.we = we; v.wa = wa; v.wd = wd; v.re = re; v.ra = ra;
    v.e_busy = eb; v.e_valid = ev; v.e_err = ee; v.e_data = ed;
    vecs.push_back(v);
  endtask

  initial begin
    logic [7:0] after4 [DEPTH];
    logic [7:0] coll_data;
    int cnt;

    drive(1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0);

    // Plan 1: two reset cycles, then exactly ten busy cycles, then all zeros.
    add(0, 0, 0, 0, 8'h00, 0, 0, 1, 0, 0, 8'h00);
    add(0, 0, 0, 0, 8'h00, 0, 0, 1, 0, 0, 8'h00);
    for (int i = 0; i < 10; i++) add(1, 0, 0, 0, 8'h00, 0, 0, (i < 9), 0, 0, 8'h00);
    for (int i = 0; i < 10; i++) add(1, 0, 0, 0, 8'h00, 1, 4'(i), 0, 1, 0, 8'h00);
    // Plan 2: write then read back.
    add(1, 0, 1, 3, 8'hA5, 0, 0, 0, 0, 0, 8'h00);
    add(1, 0, 1, 9, 8'h3C, 0, 0, 0, 0, 0, 8'h00);
    add(1, 0, 0, 0, 8'h00, 1, 3, 0, 1, 0, 8'hA5);
    add(1, 0, 0, 0, 8'h00, 1, 9, 0, 1, 0, 8'h3C);
    add(1, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 8'h3C);
    // Plan 3: same-address collision.
`ifdef MEM_WR_BYPASS_EN
    coll_data = 8'h22;
`else
    coll_data = 8'h11;
`endif
    add(1, 0, 1, 4, 8'h11, 0, 0, 0, 0, 0, 8'h3C);
    add(1, 0, 1, 4, 8'h22, 1, 4, 0, 1, 0, coll_data);
    add(1, 0, 0, 0, 8'h00, 1, 4, 0, 1, 0, 8'h22);
    // Plan 4: out-of-range accesses.
    add(1, 0, 1, 12, 8'hFF, 0, 0, 0, 0, 1, 8'h22);
    add(1, 0, 0, 0, 8'h00, 1, 12, 0, 1, 1, 8'h00);
    add(1, 0, 1, 13, 8'hEE, 1, 15, 0, 1, 1, 8'h00);
    add(1, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 8'h00);
    for (int i = 0; i < 10; i++) after4[i] = 8'h00;
    after4[3] = 8'hA5; after4[4] = 8'h22; after4[9] = 8'h3C;
    for (int i = 0; i < 10; i++) add(1, 0, 0, 0, 8'h00, 1, 4'(i), 0, 1, 0, after4[i]);

    foreach (vecs[k]) begin
      drive(vecs[k].rst_n, vecs[k].clr, vecs[k].we, vecs[k].wa, vecs[k].wd, vecs[k].re,
            vecs[k].ra);
      tick();
      n_vec++;
      if (busy !== vecs[k].e_busy || rd_valid !== vecs[k].e_valid ||
          addr_err !== vecs[k].e_err || rd_data !== vecs[k].e_data) begin
        n_bad++;
        $display("FAIL vec%0d: got busy=%b valid=%b err=%b data=%h, want busy=%b valid=%b err=%b data=%h",
                 k, busy, rd_valid, addr_err, rd_data, vecs[k].e_busy, vecs[k].e_valid,
                 vecs[k].e_err, vecs[k].e_data);
      end
      check_model($sformatf("model_vec%0d", k));
    end

    // Plan 5: fill with 5A, request a clear, repeat the request mid-sweep.
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b0, 1'b1, 4'(i), 8'h5A, 1'b0, 4'd0);
      tick();
      check_model("fill");
    end
    drive(1'b1, 1'b1, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0);
    tick();
    check_model("clr_req");
    cnt = busy ? 1 : 0;
    for (int k = 0; k < 30; k++) begin
      idle();
      if (k == 3) clr_req = 1'b1;
      tick();
      check_model("clr_sweep");
      if (!busy) break;
      cnt++;
    end
    check_val("clr_busy_cycles", cnt, 10);
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 4'(i));
      tick();
      check_model("clr_readback");
      check_val("clr_readback_data", int'(rd_data), 0);
    end

    // Plan 6: reset pulse when the sweep pointer has reached 6; write during busy is lost.
    drive(1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0);
    tick();
    check_model("rst_a");
    for (int i = 0; i < 6; i++) begin
      idle();
      tick();
      check_model("sweep_pre");
    end
    drive(1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0);
    tick();
    check_model("rst_mid");
    cnt = busy ? 1 : 0;
    for (int k = 0; k < 30; k++) begin
      idle();
      if (k == 1) begin
        wr_en = 1'b1; wr_addr = 4'd2; wr_data = 8'h77;
      end
      tick();
      check_model("resweep");
      if (!busy) break;
      cnt++;
    end
    check_val("resweep_busy_cycles", cnt, 10);
    drive(1'b1, 1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 4'd2);
    tick();
    check_model("busy_write_dropped");
    check_val("addr2_after_busy_write", int'(rd_data), 0);

    // Random traffic against the model.
    for (int k = 0; k < 400; k++) begin
      drive(($urandom_range(0, 59) != 0), ($urandom_range(0, 39) == 0),
            1'($urandom), 4'($urandom), 8'($urandom), 1'($urandom), 4'($urandom));
      tick();
      check_model("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_array_clr.md
Name: mem_array_clr

Overview:
Parametrised single-clock memory array, DEPTH words of WIDTH bits, with a hardware clear sequencer. The sequencer writes INIT_VAL to every location, one location per cycle, after reset and on request. It provides one synchronous write port and one registered read port. It is the general replacement for hand-written initial-block array clears and is synthesisable, so the clear also works after reset on silicon.

Parameters:
WIDTH, 8, data bits per word (>=1)
DEPTH, 10, number of words (>=2; need not be a power of 2)
ADDR_W, 4, address bits; must satisfy 2**ADDR_W >= DEPTH
INIT_VAL, 0, WIDTH-bit value written to every location by a clear

Ports:
clk  input  1  clock, all logic on the rising edge
rst_n  input  1  synchronous active-low reset
clr_req  input  1  one-cycle request to re-clear the whole array
busy  output  1  high while the clear sweep runs
wr_en  input  1  write strobe
wr_addr  input  ADDR_W  write address
wr_data  input  WIDTH  write data
rd_en  input  1  read strobe
rd_addr  input  ADDR_W  read address
rd_data  output  WIDTH  registered read data
rd_valid  output  1  rd_data is valid this cycle
addr_err  output  1  one-cycle pulse on an out-of-range access

Behaviour:
- States:
  - CLEAR: sweep counter clr_ptr runs 0..DEPTH-1.
  - READY: normal access.
- Reset (rst_n low at a clock edge):
  - State goes to CLEAR and clr_ptr goes to 0.
  - busy=1, rd_data=0, rd_valid=0, addr_err=0.
  - Reset asserted mid-sweep restarts the sweep at 0.
- CLEAR state:
  - Each cycle: mem[clr_ptr] <= INIT_VAL, then clr_ptr increments.
  - On the cycle that writes DEPTH-1: go to READY. busy drops on the following edge.
  - The sweep takes exactly DEPTH cycles after rst_n deasserts.
  - While busy: wr_en and rd_en are ignored, rd_valid=0, addr_err=0.
  - clr_req while busy is ignored; it does not restart or extend the sweep.
- READY state:
  - clr_req=1 makes busy=1 on the next edge and starts a fresh sweep at 0.
  - A wr_en or rd_en in the same cycle as clr_req is still serviced.
- Write:
  - wr_en=1 with wr_addr<DEPTH writes mem[wr_addr] at the edge.
- Read:
  - rd_en=1 with rd_addr<DEPTH gives rd_data=mem[rd_addr] and rd_valid=1 one cycle later (latency 1).
  - rd_en=0 gives rd_valid=0 on the next cycle; rd_data holds its last value.
- Same address read and write in one cycle: read-first. rd_data returns the old contents.
- Out of range (addr >= DEPTH, e.g. addresses 10..15 at the defaults):
  - Write is dropped and memory is unchanged.
  - Read gives rd_data=0 and rd_valid=1.
  - addr_err=1 for one cycle, aligned with the response cycle.
  - A bad read and a bad write in the same cycle give a single addr_err pulse.
- Memory is never initialised by an initial block. Only the sweep defines the contents.

Optional Feature:
- Macro: MEM_WR_BYPASS_EN.
- Defined: a read and a write to the same valid address in the same cycle return wr_data (write-first forwarding). Latency stays 1.
- Undefined: read-first behaviour as described above. Memory contents are the same in both builds.

Test Plan:
1. Reset and clear sweep:
   - Stimulus: rst_n low 2 cycles, then high.
   - Response: busy=1 for exactly 10 cycles. Then reading addresses 0..9 returns 8'h00, rd_valid=1, 1-cycle latency, with INIT_VAL=0.
2. Write then read:
   - Stimulus: write 8'hA5 to addr 3 and 8'h3C to addr 9; read addr 3 then addr 9.
   - Response: rd_data=8'hA5 then 8'h3C, each one cycle after rd_en.
3. Same-address collision:
   - Stimulus: mem[4]=8'h11; in one cycle write 8'h22 to addr 4 and read addr 4.
   - Response without the macro: rd_data=8'h11, and the next read of addr 4 returns 8'h22.
   - Response with MEM_WR_BYPASS_EN: rd_data=8'h22.
4. Out-of-range access:
   - Stimulus: write 8'hFF to addr 12; read addr 12.
   - Response: addr_err pulses on each response cycle, rd_data=0, and addresses 0..9 are unchanged.
5. Re-clear request:
   - Stimulus: fill addresses 0..9 with 8'h5A; pulse clr_req; pulse clr_req again mid-sweep.
   - Response: busy high for exactly 10 cycles from the first request (the second is ignored); all locations read 8'h00 afterwards.
6. Reset mid-sweep:
   - Stimulus: assert rst_n low for 1 cycle when clr_ptr=6.
   - Response: the sweep restarts at 0 and busy stays high 10 cycles after release. A write attempted during busy to addr 2 is not stored, so addr 2 reads 8'h00.
